// File: rtl/acondicionador_pkg.sv
// Purpose: shared types and default timing constants for the switch conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package acondicionador_pkg;

  // Slew FSM: REPOSO means codigo is settled on the target, ESPERA means
  // a step is being timed.
  typedef enum logic [0:0] {
    REPOSO = 1'b0,
    ESPERA = 1'b1
  } estado_t;

  localparam int CLK_HZ            = 27000000;
  localparam int CICLOS_REBOTE_DEF = CLK_HZ / 100;   // 10 ms
  localparam int CICLOS_PASO_DEF   = CLK_HZ / 1000;  // 1 ms, one PWM period
  localparam int ANCHO_DEF         = 4;

endpackage

// File: rtl/antirrebote_bit.sv
// Purpose: 2-flop synchroniser plus debounce counter for a single switch bit.
// Latency: a clean level change reaches estable_o 2+CICLOS_REBOTE edges later.
// Backpressure: none; the output is a level that downstream samples freely.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   dato_i    raw switch level, asynchronous to clk
//   estable_o debounced level
module antirrebote_bit
  import acondicionador_pkg::*;
#(
  parameter int CICLOS_REBOTE = CICLOS_REBOTE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dato_i,
  output logic estable_o
);

  localparam int                CNT_W   = $clog2(CICLOS_REBOTE);
  localparam logic [CNT_W-1:0]  CNT_FIN = CNT_W'(CICLOS_REBOTE - 1);

  logic             sync1_q, sync2_q;
  logic             estable_q, estable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised level disagrees with the
  // accepted one; any agreeing cycle throws the partial count away.
  always_comb begin
    estable_d = estable_q;
    cnt_d     = '0;
    if (sync2_q != estable_q) begin
      if (cnt_q == CNT_FIN) begin
        estable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      estable_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= dato_i;
      sync2_q   <= sync1_q;
      estable_q <= estable_d;
      cnt_q     <= cnt_d;
    end
  end

  assign estable_o = estable_q;

endmodule

// File: rtl/acondicionador_interruptores.sv
// Purpose: debounce the board switches and slew the PWM duty code one LSB per step.
// Latency: estable follows a switch 2+CICLOS_REBOTE edges later; each step takes CICLOS_PASO cycles.
// Backpressure: none; codigo is a level consumed continuously by the PWM stage.
//
// Ports:
//   clk           27 MHz system clock
//   rst_n         asynchronous active-low reset
//   interruptores raw switch levels (bit 0 = LSB)
//   estable       debounced switch vector, the slew target
//   codigo        slewed duty code for the PWM block
//   ocupado       high while codigo is ramping toward estable
//   cambio        one-cycle pulse in the cycle after each codigo update
module acondicionador_interruptores
  import acondicionador_pkg::*;
#(
  parameter int ANCHO         = ANCHO_DEF,
  parameter int CICLOS_REBOTE = CICLOS_REBOTE_DEF,
  parameter int CICLOS_PASO   = CICLOS_PASO_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ANCHO-1:0] interruptores,
  output logic [ANCHO-1:0] estable,
  output logic [ANCHO-1:0] codigo,
  output logic             ocupado,
  output logic             cambio
);

  localparam int                PASO_W   = $clog2(CICLOS_PASO);
  localparam logic [PASO_W-1:0] PASO_FIN = PASO_W'(CICLOS_PASO - 1);

  for (genvar i = 0; i < ANCHO; i++) begin : g_bit
    antirrebote_bit #(
      .CICLOS_REBOTE(CICLOS_REBOTE)
    ) u_antirrebote (
      .clk      (clk),
      .rst_n    (rst_n),
      .dato_i   (interruptores[i]),
      .estable_o(estable[i])
    );
  end

  estado_t           estado_q, estado_d;
  logic [PASO_W-1:0] paso_q, paso_d;
  logic [ANCHO-1:0]  codigo_q, codigo_d;
  logic              cambio_q, cambio_d;

  always_comb begin
    estado_d = estado_q;
    paso_d   = paso_q;
    codigo_d = codigo_q;
    cambio_d = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (estable != codigo_q) begin
          estado_d = ESPERA;
          paso_d   = '0;
        end
      end
      ESPERA: begin
        // Target moved back onto the current code: abandon the pending step.
        // This wins over a step due in the same cycle.
        if (estable == codigo_q) begin
          estado_d = REPOSO;
          paso_d   = '0;
        end else if (paso_q == PASO_FIN) begin
          // Direction is chosen fresh at every step so a mid-ramp target
          // change reverses the ramp without restarting the step timer.
          codigo_d = (estable > codigo_q) ? codigo_q + ANCHO'(1)
                                          : codigo_q - ANCHO'(1);
          paso_d   = '0;
          cambio_d = 1'b1;
          if (codigo_d == estable) begin
            estado_d = REPOSO;
          end
        end else begin
          paso_d = paso_q + PASO_W'(1);
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= REPOSO;
      paso_q   <= '0;
      codigo_q <= '0;
      cambio_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      paso_q   <= paso_d;
      codigo_q <= codigo_d;
      cambio_q <= cambio_d;
    end
  end

  assign codigo  = codigo_q;
  assign cambio  = cambio_q;
  assign ocupado = (estado_q == ESPERA);

endmodule

// File: tb/tb_acondicionador_interruptores.sv
// Purpose: self-checking bench for acondicionador_interruptores with short debounce/step times.
// Latency: n/a.
// Backpressure: n/a.
module tb_acondicionador_interruptores;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic [3:0] estable;
  logic [3:0] codigo;
  logic       ocupado;
  logic       cambio;

  int vectores = 0;
  int fallos   = 0;
  int ciclo    = 0;

  acondicionador_interruptores #(
    .ANCHO        (4),
    .CICLOS_REBOTE(8),
    .CICLOS_PASO  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .interruptores(sw),
    .estable      (estable),
    .codigo       (codigo),
    .ocupado      (ocupado),
    .cambio       (cambio)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ciclo <= ciclo + 1;

  // Expected code updates: value and the edge on which it must land.
  typedef struct {
    logic [3:0] cod;
    int         flanco;
  } esp_t;
  esp_t cola[$];
  esp_t sb_e;

  typedef struct {
    int         off;
    logic [3:0] est;
    logic [3:0] cod;
    logic       ocu;
    logic       cam;
  } vec_t;
  vec_t tabla [12];

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
    vectores++;
    if (act !== req) begin
      fallos++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", nombre, ciclo, act, req);
    end
  endtask

  // Must be called at a negedge; advances to the negedge following edge c.
  task automatic hasta(input int c);
    while (ciclo < c) @(negedge clk);
  endtask

  task automatic empujar(input logic [3:0] cod, input int flanco);
    esp_t e;
    e.cod    = cod;
    e.flanco = flanco;
    cola.push_back(e);
  endtask

  // Every cambio pulse must match the next expected update, both value and edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cambio === 1'b1) begin
      if (cola.size() == 0) begin
        vectores++;
        fallos++;
        $display("FAIL cambio_inesperado at edge %0d: codigo=%0h, no update expected", ciclo, codigo);
      end else begin
        sb_e = cola.pop_front();
        chk("paso_codigo", 32'(codigo), 32'(sb_e.cod));
        chk("paso_flanco", 32'(ciclo), 32'(sb_e.flanco));
      end
    end
  end

  initial begin
    int k, e, r;
    logic acc_est, acc_ocu;

    // Clean ramp 0 -> 5, offsets from the edge after the switch change.
    tabla[0]  = '{9,  4'h0, 4'h0, 1'b0, 1'b0};
    tabla[1]  = '{10, 4'h5, 4'h0, 1'b0, 1'b0};
    tabla[2]  = '{11, 4'h5, 4'h0, 1'b1, 1'b0};
    tabla[3]  = '{14, 4'h5, 4'h0, 1'b1, 1'b0};
    tabla[4]  = '{15, 4'h5, 4'h1, 1'b1, 1'b1};
    tabla[5]  = '{16, 4'h5, 4'h1, 1'b1, 1'b0};
    tabla[6]  = '{19, 4'h5, 4'h2, 1'b1, 1'b1};
    tabla[7]  = '{23, 4'h5, 4'h3, 1'b1, 1'b1};
    tabla[8]  = '{27, 4'h5, 4'h4, 1'b1, 1'b1};
    tabla[9]  = '{30, 4'h5, 4'h4, 1'b1, 1'b0};
    tabla[10] = '{31, 4'h5, 4'h5, 1'b0, 1'b1};
    tabla[11] = '{32, 4'h5, 4'h5, 1'b0, 1'b0};

    // Reset held with all switches on.
    rst_n = 1'b0;
    sw    = 4'hF;
    repeat (10) @(negedge clk);
    chk("reset_estable", 32'(estable), 0);
    chk("reset_codigo", 32'(codigo), 0);
    chk("reset_ocupado", 32'(ocupado), 0);
    chk("reset_cambio", 32'(cambio), 0);
    rst_n = 1'b1;
    r = ciclo;
    e = r + 10;
    for (int i = 1; i <= 15; i++) empujar(4'(i), e + 5 + 4 * (i - 1));
    hasta(r + 9);
    chk("rel_estable_antes", 32'(estable), 0);
    hasta(e);
    chk("rel_estable", 32'(estable), 32'hF);
    hasta(e + 63);
    chk("rel_codigo_final", 32'(codigo), 32'hF);
    chk("rel_ocupado_final", 32'(ocupado), 0);

    // Back to zero for the remaining scenarios.
    rst_n = 1'b0;
    sw    = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    // Bounce rejection on bit 0.
    acc_est = 1'b0;
    acc_ocu = 1'b0;
    for (int t = 0; t < 10; t++) begin
      sw[0] = ~sw[0];
      repeat (3) begin
        @(negedge clk);
        acc_est = acc_est | (|estable);
        acc_ocu = acc_ocu | ocupado;
      end
    end
    repeat (12) begin
      @(negedge clk);
      acc_est = acc_est | (|estable);
      acc_ocu = acc_ocu | ocupado;
    end
    chk("rebote_estable", 32'(acc_est), 0);
    chk("rebote_ocupado", 32'(acc_ocu), 0);
    chk("rebote_codigo", 32'(codigo), 0);

    // Clean ramp 0 -> 5, table driven.
    sw = 4'h5;
    k  = ciclo;
    for (int i = 1; i <= 5; i++) empujar(4'(i), k + 10 + 5 + 4 * (i - 1));
    for (int i = 0; i < 12; i++) begin
      hasta(k + tabla[i].off);
      chk($sformatf("rampa_estable_%0d", i), 32'(estable), 32'(tabla[i].est));
      chk($sformatf("rampa_codigo_%0d", i), 32'(codigo), 32'(tabla[i].cod));
      chk($sformatf("rampa_ocupado_%0d", i), 32'(ocupado), 32'(tabla[i].ocu));
      chk($sformatf("rampa_cambio_%0d", i), 32'(cambio), 32'(tabla[i].cam));
    end

    // Reversal: target F, then 2 lands while codigo is 6.
    sw = 4'hF;
    k  = ciclo;
    e  = k + 10;
    empujar(4'h6, e + 5);
    empujar(4'h5, e + 9);
    empujar(4'h4, e + 13);
    empujar(4'h3, e + 17);
    empujar(4'h2, e + 21);
    hasta(k + 8);
    sw = 4'h2;
    hasta(e + 7);
    chk("rev_estable_f", 32'(estable), 32'hF);
    chk("rev_codigo_6", 32'(codigo), 32'h6);
    hasta(e + 8);
    chk("rev_estable_2", 32'(estable), 32'h2);
    chk("rev_ocupado", 32'(ocupado), 1);
    hasta(e + 22);
    chk("rev_codigo_final", 32'(codigo), 32'h2);
    chk("rev_ocupado_final", 32'(ocupado), 0);

    // Cancel: target 7, falls back to 3 right after codigo reaches 3.
    sw = 4'h7;
    k  = ciclo;
    e  = k + 10;
    empujar(4'h3, e + 5);
    hasta(k + 8);
    sw = 4'h3;
    hasta(e + 8);
    chk("can_estable", 32'(estable), 32'h3);
    chk("can_ocupado_antes", 32'(ocupado), 1);
    hasta(e + 9);
    chk("can_ocupado", 32'(ocupado), 0);
    chk("can_codigo", 32'(codigo), 32'h3);
    chk("can_cambio", 32'(cambio), 0);
    hasta(e + 14);
    chk("can_codigo_final", 32'(codigo), 32'h3);

    // Asynchronous reset mid-ramp at codigo 7.
    sw = 4'hF;
    k  = ciclo;
    e  = k + 10;
    for (int i = 4; i <= 7; i++) empujar(4'(i), e + 5 + 4 * (i - 4));
    hasta(e + 17);
    chk("arst_codigo_7", 32'(codigo), 32'h7);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_estable", 32'(estable), 0);
    chk("arst_codigo", 32'(codigo), 0);
    chk("arst_ocupado", 32'(ocupado), 0);
    chk("arst_cambio", 32'(cambio), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r = ciclo;
    empujar(4'h1, r + 15);
    empujar(4'h2, r + 19);
    hasta(r + 9);
    chk("arst_reb_antes", 32'(estable), 0);
    hasta(r + 10);
    chk("arst_reb_estable", 32'(estable), 32'hF);
    hasta(r + 14);
    chk("arst_codigo_0", 32'(codigo), 0);
    hasta(r + 20);
    chk("arst_codigo_2", 32'(codigo), 32'h2);

    chk("cola_vacia", 32'(cola.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
    $finish;
  end

endmodule
